ptw: RTL and testbench

Hashed page-table walker for the MR core's MMU; it is the refill end of the TLB's `load`/`new_*` insert interface. On a TLB miss the MMU control requests a walk. The walker reads PTEs from the PowerPC-style hashed page table over a simple memory read port. It either pulses `load` with a fully formed entry or reports a fault. Only PTE lookup is performed: no R/C bit updates and no permission checks (the TLB checks permissions on the retried lookup).

---
 rtl/ptw.sv | 216 +++++++++++++++++++++
 tb/tb_ptw.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw.sv
// ptw - hashed page-table walker (TLB refill engine).
//
// Started by a TLB miss: it reads up to 8 PTEs from the primary PTEG and then
// up to 8 from the secondary PTEG. It then either pulses `load` with a fully
// formed TLB entry or reports a translation fault (TF). An instruction fetch
// to a no-execute segment faults (NX) at once, without touching memory. The
// walker does no R/C updates and no permission checks.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   req/req_ea/req_ifetch, seg_vsid/seg_Ks/seg_Kp/seg_N, htaborg/htabmask
//                      walk request and its translation context (latched
//                      when the request is accepted)
//   busy, done, fault_type
//                      walk status; fault_type is valid while done=1
//   mem_req/mem_addr/mem_ack/mem_rdata
//                      64-bit PTE read port ({word0, word1})
//   load, new_ea/new_pa/new_pp/new_Kp/new_Ks/new_cacheable
//                      TLB insert strobe and the entry to insert
module ptw #(
  parameter int PTEG_ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [31:0] req_ea,
  input  logic        req_ifetch,
  input  logic [23:0] seg_vsid,
  input  logic        seg_Ks,
  input  logic        seg_Kp,
  input  logic        seg_N,
  input  logic [15:0] htaborg,
  input  logic [8:0]  htabmask,
  output logic        busy,
  output logic        done,
  output logic [2:0]  fault_type,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        load,
  output logic [31:0] new_ea,
  output logic [31:0] new_pa,
  output logic [1:0]  new_pp,
  output logic        new_Kp,
  output logic        new_Ks,
  output logic        new_cacheable
);

  localparam logic [2:0] MMU_FAULT_NONE = 3'd0;
  localparam logic [2:0] MMU_FAULT_TF   = 3'd1;
  localparam logic [2:0] MMU_FAULT_NX   = 3'd2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int                IDX_W    = $clog2(PTEG_ENTRIES);
  localparam logic [IDX_W-1:0]  IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  IDX_LAST = {IDX_W{1'b1}};

  // Primary hash: low 19 VSID bits XOR the 16-bit page index.
  function automatic logic [18:0] primary_hash(input logic [23:0] vsid,
                                               input logic [15:0] page_idx);
    return vsid[18:0] ^ {3'b000, page_idx};
  endfunction

  // PTE address. HTABMASK selects which upper hash bits are ORed into
  // HTABORG. The PTEG base is 64-byte aligned, so adding idx*8 never carries
  // out of [5:0].
  function automatic logic [31:0] pte_addr(input logic [15:0]      org,
                                           input logic [8:0]       mask,
                                           input logic [18:0]      hash,
                                           input logic [IDX_W-1:0] idx);
    return {org[15:9], org[8:0] | (hash[18:10] & mask), hash[9:0], 6'b000000}
         + {{(29-IDX_W){1'b0}}, idx, 3'b000};
  endfunction

  logic [1:0]       state_r;
  logic [31:12]     ea_r;
  logic [23:0]      vsid_r;
  logic             ks_r;
  logic             kp_r;
  logic [15:0]      org_r;
  logic [8:0]       mask_r;
  logic [IDX_W-1:0] idx_r;
  logic             hsel_r;

  logic [31:0]      w0_s;
  logic [31:0]      w1_s;
  logic [18:0]      prim_hash_s;
  logic [18:0]      sec_hash_s;
  logic             pte_hit_s;
  logic [31:0]      next_addr_s;
  logic [31:0]      first_addr_s;
  logic             unused_s;

  // Word1 fields other than RPN, I and PP, and the page offset of the EA, never matter.
  assign unused_s = ^{mem_rdata[11:6], mem_rdata[4:2], req_ea[11:0]};

  // PTE decode, and the next read address on a miss.
  always_comb begin
    w0_s         = mem_rdata[63:32];
    w1_s         = mem_rdata[31:0];
    prim_hash_s  = primary_hash(vsid_r, ea_r[27:12]);
    sec_hash_s   = ~prim_hash_s;
    pte_hit_s    = w0_s[31] && (w0_s[30:7] == vsid_r) && (w0_s[6] == hsel_r)
                   && (w0_s[5:0] == ea_r[27:22]);
    first_addr_s = pte_addr(htaborg, htabmask,
                            primary_hash(seg_vsid, req_ea[27:12]), IDX_ZERO);
    if (idx_r != IDX_LAST) begin
      next_addr_s = pte_addr(org_r, mask_r, hsel_r ? sec_hash_s : prim_hash_s,
                             idx_r + IDX_ONE);
    end else begin
      // Either wrap to the secondary PTEG or the walk is over (address unused).
      next_addr_s = pte_addr(org_r, mask_r, sec_hash_s, IDX_ZERO);
    end
  end

  // Walk FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      ea_r          <= 20'h00000;
      vsid_r        <= 24'h000000;
      ks_r          <= 1'b0;
      kp_r          <= 1'b0;
      org_r         <= 16'h0000;
      mask_r        <= 9'h000;
      idx_r         <= IDX_ZERO;
      hsel_r        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fault_type    <= MMU_FAULT_NONE;
      mem_req       <= 1'b0;
      mem_addr      <= 32'h0000_0000;
      load          <= 1'b0;
      new_ea        <= 32'h0000_0000;
      new_pa        <= 32'h0000_0000;
      new_pp        <= 2'b00;
      new_Kp        <= 1'b0;
      new_Ks        <= 1'b0;
      new_cacheable <= 1'b0;
    end else begin
      done <= 1'b0;
      load <= 1'b0;
      case (state_r)
        // DONE behaves like IDLE (busy=0), so a new walk can start on its closing edge.
        ST_IDLE, ST_DONE: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state_r <= ST_IDLE;
          if (req) begin
            ea_r   <= req_ea[31:12];
            vsid_r <= seg_vsid;
            ks_r   <= seg_Ks;
            kp_r   <= seg_Kp;
            org_r  <= htaborg;
            mask_r <= htabmask;
            idx_r  <= IDX_ZERO;
            hsel_r <= 1'b0;
            if (req_ifetch && seg_N) begin
              fault_type <= MMU_FAULT_NX;
              done       <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              fault_type <= MMU_FAULT_NONE;
              busy       <= 1'b1;
              mem_req    <= 1'b1;
              mem_addr   <= first_addr_s;
              state_r    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            if (pte_hit_s) begin
              new_ea        <= {ea_r, 12'h000};
              new_pa        <= {w1_s[31:12], 12'h000};
              new_pp        <= w1_s[1:0];
              new_Ks        <= ks_r;
              new_Kp        <= kp_r;
              new_cacheable <= ~w1_s[5];
              fault_type    <= MMU_FAULT_NONE;
              done          <= 1'b1;
              load          <= 1'b1;
              busy          <= 1'b0;
              mem_req       <= 1'b0;
              state_r       <= ST_DONE;
            end else if (idx_r != IDX_LAST) begin
              idx_r    <= idx_r + IDX_ONE;
              mem_addr <= next_addr_s;
            end else if (!hsel_r) begin
              hsel_r   <= 1'b1;
              idx_r    <= IDX_ZERO;
              mem_addr <= next_addr_s;
            end else begin
              fault_type <= MMU_FAULT_TF;
              done       <= 1'b1;
              busy       <= 1'b0;
              mem_req    <= 1'b0;
              state_r    <= ST_DONE;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          mem_req <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ptw.sv
// Self-checking bench for ptw: directed walks plus randomized walks. Each
// result is compared with a reference model of the hashed page-table search.
module tb_ptw;

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_TF   = 3'd1;
  localparam logic [2:0] F_NX   = 3'd2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic [31:0] req_ea;
  logic        req_ifetch;
  logic [23:0] seg_vsid;
  logic        seg_Ks, seg_Kp, seg_N;
  logic [15:0] htaborg;
  logic [8:0]  htabmask;
  logic        busy, done;
  logic [2:0]  fault_type;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        load;
  logic [31:0] new_ea, new_pa;
  logic [1:0]  new_pp;
  logic        new_Kp, new_Ks, new_cacheable;

  always #5 clk = ~clk;

  ptw #(.PTEG_ENTRIES(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_ea(req_ea),
    .req_ifetch(req_ifetch), .seg_vsid(seg_vsid), .seg_Ks(seg_Ks),
    .seg_Kp(seg_Kp), .seg_N(seg_N), .htaborg(htaborg), .htabmask(htabmask),
    .busy(busy), .done(done), .fault_type(fault_type), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .load(load), .new_ea(new_ea), .new_pa(new_pa), .new_pp(new_pp),
    .new_Kp(new_Kp), .new_Ks(new_Ks), .new_cacheable(new_cacheable)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] mem [int unsigned];
  logic [31:0] reads[$];
  logic [31:0] exp_addrs[$];
  bit          exp_hit;
  logic [63:0] exp_data;
  int          max_stall = 0;

  logic [31:0] last_pa = 32'h0, last_ea = 32'h0;
  logic [1:0]  last_pp = 2'b00;
  logic        last_ks = 1'b0, last_kp = 1'b0, last_c = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // PTEG base address, computed arithmetically from the hashing rules.
  function automatic logic [31:0] model_pteg(input logic [23:0] vsid, input logic [31:0] ea,
                                             input logic [15:0] org, input logic [8:0] mask,
                                             input bit sec);
    int unsigned h, v, e, o, m;
    v = vsid; e = ea; o = org; m = mask;
    h = (v % 32'h80000) ^ ((e / 32'h1000) % 32'h10000);
    if (sec) h = h ^ 32'h7FFFF;
    return (o * 32'h10000) | (((h / 32'h400) & m) * 32'h10000) | ((h % 32'h400) * 32'h40);
  endfunction

  function automatic logic [63:0] make_pte(input logic v, input logic [23:0] vsid, input logic h,
                                           input logic [5:0] api, input logic [19:0] rpn,
                                           input logic ibit, input logic [1:0] pp);
    logic [5:0] junk;
    junk = 6'($urandom);
    return {v, vsid, h, api, rpn, junk, ibit, 3'b000, pp};
  endfunction

  // Reference search: primary PTEG then secondary, lowest index first.
  task automatic model_walk(input logic [31:0] ea, input logic [23:0] vsid,
                            input logic [15:0] org, input logic [8:0] mask);
    exp_addrs.delete();
    exp_hit  = 1'b0;
    exp_data = 64'h0;
    for (int s = 0; s < 2 && !exp_hit; s++) begin
      for (int i = 0; i < 8 && !exp_hit; i++) begin
        logic [31:0] a;
        logic [63:0] d;
        logic [31:0] w0;
        a = model_pteg(vsid, ea, org, mask, s[0]) + 32'(i * 8);
        exp_addrs.push_back(a);
        d  = mem.exists(a) ? mem[a] : 64'h0;
        w0 = d[63:32];
        if (w0[31] && w0[30:7] == vsid && w0[6] == s[0] && w0[5:0] == ea[27:22]) begin
          exp_hit  = 1'b1;
          exp_data = d;
        end
      end
    end
  endtask

  // Memory responder: random ack stalls, records every acknowledged address.
  bit          in_req = 1'b0;
  int          remaining = 0;
  logic [31:0] cur_addr = 32'h0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 64'h0;
    forever begin
      @(negedge clk);
      if (!reset_n || !mem_req) begin
        mem_ack = 1'b0;
        in_req  = 1'b0;
      end else begin
        if (!in_req) begin
          in_req    = 1'b1;
          cur_addr  = mem_addr;
          remaining = $urandom_range(0, max_stall);
        end else begin
          check("addr_stable", 64'(mem_addr), 64'(cur_addr));
        end
        if (remaining == 0) begin
          logic [63:0] g;
          g = {$urandom, $urandom};
          g[63] = 1'b0;
          mem_ack   = 1'b1;
          mem_rdata = mem.exists(cur_addr) ? mem[cur_addr] : g;
          reads.push_back(cur_addr);
          in_req = 1'b0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = {$urandom, $urandom};
          remaining--;
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},    64'(busy), 64'(1'b0));
    check({tag, "_done"},    64'(done), 64'(1'b0));
    check({tag, "_load"},    64'(load), 64'(1'b0));
    check({tag, "_mem_req"}, 64'(mem_req), 64'(1'b0));
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'(32'h0));
    check({tag, "_fault"},   64'(fault_type), 64'(F_NONE));
    check({tag, "_new"}, {new_ea, new_pa}, 64'h0);
    check({tag, "_new_bits"}, 64'({new_pp, new_Kp, new_Ks, new_cacheable}), 64'(5'b0));
  endtask

  task automatic run_walk(input string tag, input logic [31:0] ea, input logic [23:0] vsid,
                          input logic ks, input logic kp, input logic nx, input logic ifetch,
                          input logic [15:0] org, input logic [8:0] mask,
                          input int stall, input bit timed, input bit poke);
    bit          expect_nx, got_done, saw_req;
    int          cycles;
    logic [2:0]  exp_fault;
    logic [31:0] w1;
    expect_nx = ifetch && nx;
    if (expect_nx) begin
      exp_addrs.delete();
      exp_hit = 1'b0;
    end else begin
      model_walk(ea, vsid, org, mask);
    end
    max_stall = stall;
    reads.delete();
    @(negedge clk);
    req_ea = ea; seg_vsid = vsid; seg_Ks = ks; seg_Kp = kp; seg_N = nx;
    req_ifetch = ifetch; htaborg = org; htabmask = mask; req = 1'b1;
    @(posedge clk);
    #1;
    // Context must have been latched: scramble it for the rest of the walk.
    req_ea = $urandom; seg_vsid = 24'($urandom); htaborg = 16'($urandom);
    htabmask = 9'($urandom); seg_Ks = ~ks; seg_Kp = ~kp;
    cycles = 0; got_done = 1'b0; saw_req = 1'b0;
    while (!got_done && cycles < 500) begin
      @(negedge clk);
      cycles++;
      if (mem_req) saw_req = 1'b1;
      if (done) begin
        got_done = 1'b1;
      end else begin
        check({tag, "_busy"}, 64'(busy), 64'(1'b1));
        if (poke && cycles == 2) req = 1'b0;
        if (poke && cycles == 4) begin
          req = 1'b1;
          req_ea = $urandom;
        end
      end
    end
    check({tag, "_done_seen"}, 64'(got_done), 64'(1'b1));
    if (got_done) begin
      exp_fault = expect_nx ? F_NX : (exp_hit ? F_NONE : F_TF);
      check({tag, "_fault"}, 64'(fault_type), 64'(exp_fault));
      check({tag, "_load"}, 64'(load), 64'(exp_hit && !expect_nx));
      check({tag, "_nreads"}, 64'(reads.size()), 64'(exp_addrs.size()));
      for (int i = 0; i < reads.size() && i < exp_addrs.size(); i++)
        check($sformatf("%s_addr%0d", tag, i), 64'(reads[i]), 64'(exp_addrs[i]));
      if (timed)
        check({tag, "_latency"}, 64'(cycles), 64'(expect_nx ? 1 : exp_addrs.size() + 1));
      if (expect_nx) check({tag, "_no_mem_req"}, 64'(saw_req), 64'(1'b0));
      if (exp_hit && !expect_nx) begin
        w1      = exp_data[31:0];
        last_pa = w1 & 32'hFFFF_F000;
        last_pp = 2'(w1 % 4);
        last_c  = ((w1 / 32) % 2) == 0;
        last_ea = ea & 32'hFFFF_F000;
        last_ks = ks;
        last_kp = kp;
      end
      check({tag, "_new_ea"}, 64'(new_ea), 64'(last_ea));
      check({tag, "_new_pa"}, 64'(new_pa), 64'(last_pa));
      check({tag, "_new_bits"}, 64'({new_pp, new_Ks, new_Kp, new_cacheable}),
            64'({last_pp, last_ks, last_kp, last_c}));
    end
    req = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 64'({busy, done, load}), 64'(3'b000));
  endtask

  initial begin
    logic [23:0] vsid;
    logic [31:0] ea, base;
    logic [15:0] org;
    logic [8:0]  mask;
    reset_n = 1'b0; req = 1'b0; req_ea = 32'h0; req_ifetch = 1'b0; seg_vsid = 24'h0;
    seg_Ks = 1'b0; seg_Kp = 1'b0; seg_N = 1'b0; htaborg = 16'h0; htabmask = 9'h0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    // Primary hit at entry 0, single-cycle ack.
    vsid = 24'h000123; ea = 32'h1234_5000;
    base = model_pteg(vsid, ea, 16'h0010, 9'h000, 1'b0);
    mem[base] = make_pte(1'b1, vsid, 1'b0, ea[27:22], 20'hABCDE, 1'b0, 2'b10);
    run_walk("prim_hit", ea, vsid, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 9'h000, 0, 1'b1, 1'b0);

    // Secondary hit at entry 3; primary entries all invalid, secondary entry 1 has H=0.
    mem.delete();
    vsid = 24'h000ABC; ea = 32'h5678_9000; org = 16'h0020; mask = 9'h00F;
    for (int i = 0; i < 8; i++)
      mem[model_pteg(vsid, ea, org, mask, 1'b0) + 32'(i * 8)] =
        make_pte(1'b0, vsid, 1'b0, ea[27:22], 20'h11111, 1'b0, 2'b01);
    base = model_pteg(vsid, ea, org, mask, 1'b1);
    mem[base + 32'd8]  = make_pte(1'b1, vsid, 1'b0, ea[27:22], 20'h22222, 1'b0, 2'b01);
    mem[base + 32'd24] = make_pte(1'b1, vsid, 1'b1, ea[27:22], 20'h33333, 1'b1, 2'b11);
    run_walk("sec_hit", ea, vsid, 1'b0, 1'b1, 1'b0, 1'b1, org, mask, 0, 1'b1, 1'b0);
    check("sec_hit_12reads", 64'(reads.size()), 64'(12));
    if (reads.size() > 8) check("sec_hit_9th_addr", 64'(reads[8]), 64'(base));

    // No match in either PTEG; entry fields from the previous hit must hold.
    mem.delete();
    run_walk("no_match", 32'hDEAD_B000, 24'h0F0F0F, 1'b1, 1'b1, 1'b0, 1'b0,
             16'h1234, 9'h0AA, 0, 1'b1, 1'b0);
    check("no_match_16reads", 64'(reads.size()), 64'(16));

    // ITLB request to a no-execute segment.
    run_walk("nx", 32'h4000_0000, 24'h000777, 1'b0, 1'b0, 1'b1, 1'b1,
             16'h0040, 9'h000, 0, 1'b1, 1'b0);

    // HTABMASK all ones with hash[18:10]=0x155.
    mem.delete();
    vsid = 24'h055400; ea = 32'h0000_0000;
    mem[model_pteg(vsid, ea, 16'h0000, 9'h1FF, 1'b0)] =
      make_pte(1'b1, vsid, 1'b0, 6'h00, 20'h0F0F0, 1'b0, 2'b00);
    run_walk("mask", ea, vsid, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 9'h1FF, 0, 1'b1, 1'b0);
    if (reads.size() > 0) check("mask_bits", 64'((reads[0] >> 16) & 32'h1FF), 64'(9'h155));

    // Randomized walks with ack stalls and a second req pulse mid-walk.
    for (int t = 0; t < 30; t++) begin
      int n_match;
      vsid = 24'($urandom); ea = $urandom; org = 16'($urandom); mask = 9'($urandom);
      mem.delete();
      for (int k = 0; k < 4; k++) begin
        int s, i, kind;
        logic [63:0] p;
        s = $urandom_range(0, 1); i = $urandom_range(0, 7); kind = $urandom_range(0, 3);
        case (kind)
          0: p = make_pte(1'b1, vsid, s[0], ea[27:22] ^ 6'h01, 20'($urandom), 1'b0, 2'b00);
          1: p = make_pte(1'b1, vsid ^ 24'h800000, s[0], ea[27:22], 20'($urandom), 1'b0, 2'b00);
          2: p = make_pte(1'b1, vsid, ~s[0], ea[27:22], 20'($urandom), 1'b0, 2'b00);
          default: p = make_pte(1'b0, vsid, s[0], ea[27:22], 20'($urandom), 1'b0, 2'b00);
        endcase
        mem[model_pteg(vsid, ea, org, mask, s[0]) + 32'(i * 8)] = p;
      end
      n_match = $urandom_range(0, 2);
      for (int k = 0; k < n_match; k++) begin
        int s, i;
        s = $urandom_range(0, 1); i = $urandom_range(0, 7);
        mem[model_pteg(vsid, ea, org, mask, s[0]) + 32'(i * 8)] =
          make_pte(1'b1, vsid, s[0], ea[27:22], 20'($urandom), 1'($urandom), 2'($urandom));
      end
      run_walk($sformatf("rnd%0d", t), ea, vsid, 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0), 1'($urandom), org, mask, 5, 1'b0, 1'b1);
    end

    // Reset in the middle of a stalled walk.
    mem.delete();
    max_stall = 5;
    @(negedge clk);
    req_ea = 32'h0BAD_0000; seg_vsid = 24'h123456; seg_N = 1'b0; req_ifetch = 1'b0;
    htaborg = 16'h0100; htabmask = 9'h003; req = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("mid_reset");
    req = 1'b0;
    last_pa = 32'h0; last_ea = 32'h0; last_pp = 2'b00;
    last_ks = 1'b0; last_kp = 1'b0; last_c = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", 64'({busy, mem_req, done}), 64'(3'b000));

    // Walk after reset recovery.
    vsid = 24'h00BEEF; ea = 32'h7654_3000;
    mem[model_pteg(vsid, ea, 16'h0200, 9'h010, 1'b0) + 32'd16] =
      make_pte(1'b1, vsid, 1'b0, ea[27:22], 20'h5A5A5, 1'b1, 2'b01);
    run_walk("after_reset", ea, vsid, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0200, 9'h010, 0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
